fifo_rd_downsizer: RTL and testbench

FIFO_RD_DOWNSIZER -- requirements
Module: fifo_rd_downsizer

---
 rtl/fifo_rd_downsizer_pkg.sv | 10 +
 rtl/fifo_rd_downsizer_if.sv | 42 ++++
 rtl/fifo_rd_downsizer.sv | 91 +++++++++
 tb/tb_fifo_rd_downsizer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_downsizer_pkg.sv
// Shared types for the FIFO read-side width downsizer.
// Holds the state encoding of the single-word holding register.
package fifo_rd_downsizer_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_rd_downsizer_if.sv
// Bundle of the upstream FIFO pop port, packet length input and AXI-Stream output.
// The master modport is the downsizer side; slave is the FIFO/sink/stimulus side.
interface fifo_rd_downsizer_if #(
  parameter int IN_BITS  = 64,
  parameter int OUT_BITS = 16,
  parameter int LEN_BITS = 16
);
  logic                fifo_rd;
  logic                fifo_ready_rd;
  logic [IN_BITS-1:0]  fifo_data;
  logic [LEN_BITS-1:0] pkt_len;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [OUT_BITS-1:0] m_axis_tdata;
  logic                m_axis_tlast;
  logic                pkt_done;

  modport master (
    output fifo_rd,
    input  fifo_ready_rd,
    input  fifo_data,
    input  pkt_len,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tlast,
    output pkt_done
  );

  modport slave (
    input  fifo_rd,
    output fifo_ready_rd,
    output fifo_data,
    output pkt_len,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tlast,
    input  pkt_done
  );

endinterface

// File: rtl/fifo_rd_downsizer.sv
// Pops IN_BITS words from an upstream FIFO and emits them as OUT_BITS stream beats,
// LSB slice first, with word-aligned packets framed by a programmable beat count.
module fifo_rd_downsizer
  import fifo_rd_downsizer_pkg::*;
#(
  parameter int IN_BITS  = 64,
  parameter int OUT_BITS = 16,
  parameter int LEN_BITS = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  fifo_rd_downsizer_if.master bus
);

  localparam int RATIO = IN_BITS / OUT_BITS;
  localparam int SUB_W = $clog2(RATIO);

  state_t              state;
  logic [IN_BITS-1:0]  hold_q;
  logic [SUB_W-1:0]    sub_cnt;
  logic [LEN_BITS-1:0] beat_cnt;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] eff_len;
  logic                pkt_done_q;
  logic                tvalid;
  logic                tlast;
  logic                accept;
  logic                word_end;
  logic                load;
  logic [OUT_BITS-1:0] slices [RATIO];

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slices[gi] = hold_q[gi*OUT_BITS +: OUT_BITS];
    end
  endgenerate

  // The first beat of a packet sees the live length; later beats use the latched copy.
  assign eff_len  = (beat_cnt == '0) ? bus.pkt_len : len_q;
  assign tvalid   = (state == FULL);
  assign tlast    = tvalid && (eff_len != '0) && (beat_cnt == eff_len - LEN_BITS'(1));
  assign accept   = tvalid && bus.m_axis_tready;
  assign word_end = (sub_cnt == SUB_W'(RATIO - 1)) || tlast;
  // Refill on the same edge the last slice leaves, so words stream without a bubble.
  assign load     = aresetn && bus.fifo_ready_rd &&
                    ((state == EMPTY) || (accept && word_end));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= EMPTY;
      hold_q     <= '0;
      sub_cnt    <= '0;
      beat_cnt   <= '0;
      len_q      <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      if (load) begin
        hold_q  <= bus.fifo_data;
        sub_cnt <= '0;
        state   <= FULL;
      end else if (accept) begin
        if (word_end) begin
          state   <= EMPTY;
          sub_cnt <= '0;
        end else begin
          sub_cnt <= sub_cnt + SUB_W'(1);
        end
      end

      if (accept) begin
        if (beat_cnt == '0) begin
          len_q <= bus.pkt_len;
        end
        if (tlast) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + LEN_BITS'(1);
        end
      end

      pkt_done_q <= accept && tlast;
    end
  end

  assign bus.fifo_rd       = load;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tdata  = slices[sub_cnt];
  assign bus.m_axis_tlast  = tlast;
  assign bus.pkt_done      = pkt_done_q;

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// Directed bench for fifo_rd_downsizer (64 -> 16 bits) with a small upstream FIFO model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_fifo_rd_downsizer;

  localparam logic [63:0] W0 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W1 = 64'h8888_7777_6666_5555;
  localparam logic [63:0] W2 = 64'hCCCC_BBBB_AAAA_9999;

  logic aclk;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] fmem [16];
  logic [4:0]  wr_ptr  = '0;
  logic [4:0]  rd_ptr  = '0;
  int          pop_cnt = 0;

  fifo_rd_downsizer_if #(.IN_BITS(64), .OUT_BITS(16), .LEN_BITS(16)) bus ();

  fifo_rd_downsizer #(.IN_BITS(64), .OUT_BITS(16), .LEN_BITS(16)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  assign bus.fifo_ready_rd = (rd_ptr != wr_ptr);
  assign bus.fifo_data     = fmem[rd_ptr[3:0]];

  always @(posedge aclk) begin
    if (bus.fifo_rd) begin
      rd_ptr  <= rd_ptr + 5'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic push(input logic [63:0] w);
    fmem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic beat(input string tag, input logic [15:0] d, input logic l);
    #1;
    chk({tag, "_valid"}, 64'(bus.m_axis_tvalid), 64'd1);
    chk({tag, "_data"},  64'(bus.m_axis_tdata),  64'(d));
    chk({tag, "_last"},  64'(bus.m_axis_tlast),  64'(l));
  endtask

  initial begin
    logic [15:0] e2 [8];
    logic [15:0] e6 [12];
    e2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    e6 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666,
           16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC};

    aresetn           = 1'b0;
    bus.m_axis_tready = 1'b0;
    bus.pkt_len       = 16'd0;
    repeat (2) tick();
    #1;
    chk("rst_valid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_last",  64'(bus.m_axis_tlast),  64'd0);
    chk("rst_data",  64'(bus.m_axis_tdata),  64'd0);
    chk("rst_done",  64'(bus.pkt_done),      64'd0);
    tick();
    aresetn = 1'b1;

    // Single word, single packet of 4 beats
    tick();
    bus.pkt_len = 16'd4; bus.m_axis_tready = 1'b1; push(W0);
    #1;
    chk("t1_load_rd", 64'(bus.fifo_rd), 64'd1);
    chk("t1_load_valid", 64'(bus.m_axis_tvalid), 64'd0);
    tick(); beat("t1_b1", 16'h1111, 1'b0);
    tick(); beat("t1_b2", 16'h2222, 1'b0);
    tick(); beat("t1_b3", 16'h3333, 1'b0);
    tick(); beat("t1_b4", 16'h4444, 1'b1);
    chk("t1_b4_rd", 64'(bus.fifo_rd), 64'd0);
    tick(); #1;
    chk("t1_done", 64'(bus.pkt_done), 64'd1);
    chk("t1_idle", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t1_pops", 64'(pop_cnt), 64'd1);
    tick(); #1;
    chk("t1_done_pulse", 64'(bus.pkt_done), 64'd0);

    // Two queued words, 8-beat packet, no bubble
    tick();
    bus.pkt_len = 16'd8; push(W0); push(W1);
    #1;
    chk("t2_load_rd", 64'(bus.fifo_rd), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      beat($sformatf("t2_b%0d", i + 1), e2[i], (i == 7));
      if (i == 3) chk("t2_b4_rd", 64'(bus.fifo_rd), 64'd1);
    end
    tick(); #1;
    chk("t2_done", 64'(bus.pkt_done), 64'd1);
    chk("t2_idle", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t2_pops", 64'(pop_cnt), 64'd3);

    // Length 3: last slice of W0 discarded, next packet starts at W1 slice 0
    tick();
    bus.pkt_len = 16'd3; push(W0); push(W1);
    #1;
    tick(); beat("t3_b1", 16'h1111, 1'b0);
    tick(); beat("t3_b2", 16'h2222, 1'b0);
    tick(); beat("t3_b3", 16'h3333, 1'b1);
    chk("t3_b3_rd", 64'(bus.fifo_rd), 64'd1);
    tick(); beat("t3_b4", 16'h5555, 1'b0);
    chk("t3_done1", 64'(bus.pkt_done), 64'd1);
    tick(); beat("t3_b5", 16'h6666, 1'b0);
    tick(); beat("t3_b6", 16'h7777, 1'b1);
    chk("t3_b6_rd", 64'(bus.fifo_rd), 64'd0);
    tick(); #1;
    chk("t3_done2", 64'(bus.pkt_done), 64'd1);
    chk("t3_idle", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t3_pops", 64'(pop_cnt), 64'd5);

    // Stalls mid-word and on the last beat; pkt_len change mid-packet ignored
    tick();
    bus.pkt_len = 16'd4; push(W0);
    #1;
    tick(); beat("t4_b1", 16'h1111, 1'b0);
    tick(); bus.m_axis_tready = 1'b0; bus.pkt_len = 16'd2;
    beat("t4_stall1", 16'h2222, 1'b0);
    tick(); beat("t4_stall2", 16'h2222, 1'b0);
    tick(); bus.m_axis_tready = 1'b1;
    beat("t4_b2", 16'h2222, 1'b0);
    tick(); beat("t4_b3", 16'h3333, 1'b0);
    tick(); bus.m_axis_tready = 1'b0;
    beat("t4_stall3", 16'h4444, 1'b1);
    tick(); beat("t4_stall4", 16'h4444, 1'b1);
    chk("t4_stall_done", 64'(bus.pkt_done), 64'd0);
    tick(); bus.m_axis_tready = 1'b1;
    beat("t4_b4", 16'h4444, 1'b1);
    tick(); #1;
    chk("t4_done", 64'(bus.pkt_done), 64'd1);
    chk("t4_idle", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t4_pops", 64'(pop_cnt), 64'd6);

    // Reset after beat 2 of an 8-beat packet
    tick();
    bus.pkt_len = 16'd8; push(W0); push(W1);
    #1;
    tick(); beat("t5_b1", 16'h1111, 1'b0);
    tick(); beat("t5_b2", 16'h2222, 1'b0);
    tick(); aresetn = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t5_rst_last",  64'(bus.m_axis_tlast),  64'd0);
    chk("t5_rst_data",  64'(bus.m_axis_tdata),  64'd0);
    tick(); bus.pkt_len = 16'd2;
    #1;
    chk("t5_rst_pops", 64'(pop_cnt), 64'd7);
    tick(); aresetn = 1'b1;
    #1;
    chk("t5_rel_rd", 64'(bus.fifo_rd), 64'd1);
    tick(); beat("t5_b3", 16'h5555, 1'b0);
    tick(); beat("t5_b4", 16'h6666, 1'b1);
    tick(); #1;
    chk("t5_done", 64'(bus.pkt_done), 64'd1);
    chk("t5_idle", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t5_pops", 64'(pop_cnt), 64'd8);

    // Single-beat packet
    tick();
    bus.pkt_len = 16'd1; push(W0);
    #1;
    tick(); beat("t6_b1", 16'h1111, 1'b1);
    chk("t6_b1_rd", 64'(bus.fifo_rd), 64'd0);
    tick(); #1;
    chk("t6_done", 64'(bus.pkt_done), 64'd1);
    chk("t6_idle", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t6_pops", 64'(pop_cnt), 64'd9);

    // Unbounded length: 12 beats, never tlast, never pkt_done
    tick();
    bus.pkt_len = 16'd0; push(W0); push(W1); push(W2);
    #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      beat($sformatf("t7_b%0d", i + 1), e6[i], 1'b0);
      chk($sformatf("t7_b%0d_done", i + 1), 64'(bus.pkt_done), 64'd0);
    end
    tick(); #1;
    chk("t7_done", 64'(bus.pkt_done), 64'd0);
    chk("t7_idle", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t7_pops", 64'(pop_cnt), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
